// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FWFT FIFO with occupancy count and almost-full/empty thresholds.
// Sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int ADDR_BIT = 4,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    input_data,
    input  logic                write,
    input  logic                read,
    output logic [WIDTH-1:0]    output_data,
    output logic                empty,
    output logic                full,
    output logic                almost_empty,
    output logic                almost_full,
    output logic [ADDR_BIT:0]   count,
    input  logic                clr_err,
    output logic                overflow,
    output logic                underflow
);

    localparam logic [ADDR_BIT:0]   C_DEPTH = (ADDR_BIT+1)'(DEPTH);
    localparam logic [ADDR_BIT:0]   C_AF    = (ADDR_BIT+1)'(AF_LEVEL);
    localparam logic [ADDR_BIT:0]   C_AE    = (ADDR_BIT+1)'(AE_LEVEL);
    localparam logic [ADDR_BIT-1:0] C_LAST  = ADDR_BIT'(DEPTH - 1);
    localparam logic [ADDR_BIT-1:0] C_ONE   = ADDR_BIT'(1);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [ADDR_BIT-1:0] r_write_addr;
    logic [ADDR_BIT-1:0] r_read_addr;
    logic [ADDR_BIT:0]   r_count;
    logic                w_rd_ok;
    logic                w_wr_ok;

    assign empty        = (r_count == {(ADDR_BIT+1){1'b0}});
    assign full         = (r_count == C_DEPTH);
    assign almost_empty = (r_count <= C_AE);
    assign almost_full  = (r_count >= C_AF);
    assign count        = r_count;

    // A write on full is allowed when the same edge pops the head slot.
    assign w_rd_ok = read & ~empty;
    assign w_wr_ok = write & (~full | read);

    assign output_data = empty ? {WIDTH{1'b0}} : r_mem[r_read_addr];

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_write_addr] <= input_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write_addr <= {ADDR_BIT{1'b0}};
            r_read_addr  <= {ADDR_BIT{1'b0}};
            r_count      <= {(ADDR_BIT+1){1'b0}};
        end else begin
            if (w_wr_ok) begin
                r_write_addr <= (r_write_addr == C_LAST) ? {ADDR_BIT{1'b0}} : r_write_addr + C_ONE;
            end
            if (w_rd_ok) begin
                r_read_addr <= (r_read_addr == C_LAST) ? {ADDR_BIT{1'b0}} : r_read_addr + C_ONE;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + {{ADDR_BIT{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{ADDR_BIT{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags; a fresh error beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (read && !w_rd_ok) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic w_unused_clr_err;
    assign w_unused_clr_err = clr_err;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

endmodule
